boot_loader_ctrl: RTL

- Sequences the boot hand-off for the fetch stage.
- On `start`, copies `COPY_WORDS` 32-bit words from the boot ROM into RAM, then reads every copied word back and compares it against ROM.
- On a clean verify, raises `execute_from_ram` so STAGE0 fetches from RAM.
- Owns the RAM address/write port while busy and passes the CPU fetch address through when idle.

---
 rtl/boot_pkg.sv | 15 +
 rtl/boot_loader_ctrl_ram_port_mux.sv | 17 +
 rtl/boot_loader_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and widths for the boot copy/verify controller.
package boot_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COPY   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

endpackage

// File: rtl/boot_loader_ctrl_ram_port_mux.sv
// RAM port arbitration: the sequencer owns address and write enable while busy,
// otherwise the CPU fetch address passes straight through and writes are blocked.
module ram_port_mux
    import boot_pkg::*;
(
    input  logic              busy,
    input  logic [ADDR_W-1:0] fsm_address,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              fsm_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_is_write
);

    assign ram_address  = busy ? fsm_address : cpu_address;
    assign ram_is_write = busy & fsm_write;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies COPY_WORDS words from boot ROM into RAM, verifies them, then hands
// fetch over to RAM; reports the first mismatching word index on failure.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int                COPY_WORDS = 256,
    parameter logic [ADDR_W-1:0] ROM_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0] RAM_BASE   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cpu_ram_address,
    output logic [ADDR_W-1:0] brom_address,
    input  logic [WORD_W-1:0] brom_value,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_in,
    output logic              ram_is_write,
    input  logic [WORD_W-1:0] ram_value,
    output logic              execute_from_ram,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] fail_index
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] fsm_address;
    logic              in_copy;
    logic              last_idx;
    logic              word_match;

    // Compare in 32 bits so COPY_WORDS = 65536 terminates at idx = 16'hFFFF.
    assign last_idx   = (32'(idx) == COPY_WORDS - 1);
    assign in_copy    = (state == ST_COPY);
    assign word_match = (ram_value == brom_value);

    // 16-bit sums wrap naturally past 16'hFFFF.
    assign brom_address = ROM_BASE + idx;
    assign fsm_address  = RAM_BASE + idx;
    assign ram_in       = in_copy ? brom_value : '0;

    ram_port_mux u_ram_port_mux (
        .busy         (busy),
        .fsm_address  (fsm_address),
        .cpu_address  (cpu_ram_address),
        .fsm_write    (in_copy),
        .ram_address  (ram_address),
        .ram_is_write (ram_is_write)
    );

    // NOTE: state and registered outputs use non-blocking assignments and an
    // asynchronous reset, so a mid-copy reset kills ram_is_write without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            execute_from_ram <= 1'b0;
            fail_index       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state            <= ST_COPY;
                        idx              <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        error            <= 1'b0;
                        execute_from_ram <= 1'b0;
                        fail_index       <= '0;
                    end
                end
                ST_COPY: begin
                    if (last_idx) begin
                        state <= ST_VERIFY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                ST_VERIFY: begin
                    if (!word_match) begin
                        state      <= ST_FAIL;
                        fail_index <= idx;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                    end else if (last_idx) begin
                        state            <= ST_DONE;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        execute_from_ram <= 1'b1;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
